// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, over a start/done handshake.
// Subtraction is performed as a + ~b + ~cin; cout reports borrow in that mode.
module serial_addsub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, rb_q, acc_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, sub_q;
    logic             busy_d, done_d;
    logic             load, step, finish;
    logic             sum_bit, c_nxt, last_bit;

    // One full-adder slice on the current LSBs
    assign sum_bit  = ra_q[0] ^ rb_q[0] ^ c_q;
    assign c_nxt    = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last_bit) begin
                    finish  = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
            if (load) begin
                ra_q  <= a;
                rb_q  <= sub ? ~b : b;
                c_q   <= cin ^ sub;
                sub_q <= sub;
                cnt_q <= '0;
            end
            if (step) begin
                ra_q  <= ra_q >> 1;
                rb_q  <= rb_q >> 1;
                acc_q <= {sum_bit, acc_q[WIDTH-1:1]};
                c_q   <= c_nxt;
                cnt_q <= cnt_q + CW'(1);
            end
            // Final slice: carry into the MSB is c_q, carry out of it is c_nxt
            if (finish) begin
                s    <= {sum_bit, acc_q[WIDTH-1:1]};
                cout <= c_nxt ^ sub_q;
                ovf  <= c_q ^ c_nxt;
            end
        end
    end

endmodule
